// File: rtl/ex_alu_stage_pkg.sv
// Shared execute-stage definitions: ALU control codes, forward selects, EX/MEM payload.
package ex_alu_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    // ALUControl codes produced by the ALU decoder
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    // Operand forwarding selects; 2'b11 falls back to the register-file value
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // EX/MEM holding register payload
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] wdata;
        logic            zero;
        logic            illegal;
    } exm_t;

    // Forwarding mux shared by both operands
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf_val,
        input logic [XLEN-1:0] wb_val,
        input logic [XLEN-1:0] mem_val
    );
        logic [XLEN-1:0] val;
        val = rf_val;
        case (sel)
            FWD_WB:  val = wb_val;
            FWD_MEM: val = mem_val;
            default: val = rf_val;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/ex_alu_stage_if.sv
// ID/EX-to-MEM bundle of the execute stage: operands, forwarding, handshakes, EX/MEM outputs.
interface ex_alu_stage_if;
    import ex_alu_stage_pkg::*;

    // upstream handshake and operands
    logic            validE;
    logic            readyE;
    logic [2:0]      ALUControlE;
    logic            ALUSrcE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] ResultW;

    // downstream handshake and holding register
    logic             FlushM;
    logic             readyM;
    logic             validM;
    logic [XLEN-1:0]  ALUResultM;
    logic [XLEN-1:0]  WriteDataM;
    logic             ZeroM;
    logic             IllegalM;
    logic [CNT_W-1:0] OpCountM;

    // Pipeline side that feeds the stage and consumes its result
    modport master (
        output validE, ALUControlE, ALUSrcE, ForwardAE, ForwardBE,
               RD1E, RD2E, ImmExtE, ResultW, FlushM, readyM,
        input  readyE, validM, ALUResultM, WriteDataM, ZeroM, IllegalM, OpCountM
    );

    // The execute stage itself
    modport slave (
        input  validE, ALUControlE, ALUSrcE, ForwardAE, ForwardBE,
               RD1E, RD2E, ImmExtE, ResultW, FlushM, readyM,
        output readyE, validM, ALUResultM, WriteDataM, ZeroM, IllegalM, OpCountM
    );

endinterface

// File: rtl/ex_alu_stage_alu_core.sv
// Combinational ALU: add/sub/and/or/slt with zero and illegal-code flags.
module ex_alu_stage_alu_core
    import ex_alu_stage_pkg::*;
(
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [2:0]      alu_control,
    output logic [XLEN-1:0] result_c,
    output logic            zero_c,
    output logic            illegal_c
);

    logic [XLEN-1:0] diff;
    logic            neg;
    logic            ovf;
    logic            lt;

    // Signed less-than derived from the subtraction: N xor V
    assign diff = src_a - src_b;
    assign neg  = diff[XLEN-1];
    assign ovf  = (src_a[XLEN-1] ^ src_b[XLEN-1]) & (diff[XLEN-1] ^ src_a[XLEN-1]);
    assign lt   = neg ^ ovf;

    // Operation select; unsupported codes yield zero and raise the illegal flag
    always_comb begin
        result_c  = '0;
        illegal_c = 1'b0;
        case (alu_control)
            ALU_ADD: result_c = src_a + src_b;
            ALU_SUB: result_c = diff;
            ALU_AND: result_c = src_a & src_b;
            ALU_OR:  result_c = src_a | src_b;
            ALU_SLT: result_c = XLEN'(lt);
            default: illegal_c = 1'b1;
        endcase
    end

    // Zero flag covers the full result, slt included
    assign zero_c = (result_c == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: forwarding muxes, ALU, single-entry EX/MEM holding register and op counter.
module ex_alu_stage
    import ex_alu_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    ex_alu_stage_if.slave bus
);

    logic [XLEN-1:0]  src_a;
    logic [XLEN-1:0]  fwd_b;
    logic [XLEN-1:0]  src_b;
    logic [XLEN-1:0]  alu_result;
    logic             alu_zero;
    logic             alu_illegal;
    logic             ready;
    logic             accept;
    logic             handoff;
    exm_t             exm_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    // Operand selection; the MEM forward path taps the holding register even when it is empty
    assign src_a = fwd_mux(bus.ForwardAE, bus.RD1E, bus.ResultW, exm_q.result);
    assign fwd_b = fwd_mux(bus.ForwardBE, bus.RD2E, bus.ResultW, exm_q.result);
    assign src_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;

    ex_alu_stage_alu_core u_alu_core (
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (bus.ALUControlE),
        .result_c    (alu_result),
        .zero_c      (alu_zero),
        .illegal_c   (alu_illegal)
    );

    // Handshake: the register frees up when empty or being drained this cycle
    assign ready   = ~valid_q | bus.readyM;
    assign accept  = bus.validE & ready & ~bus.FlushM;
    assign handoff = valid_q & bus.readyM;

    // Holding register: flush wins, stall freezes, accept reloads, otherwise drain to empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            exm_q   <= '0;
        end else if (bus.FlushM) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            exm_q   <= '{result: alu_result, wdata: fwd_b, zero: alu_zero, illegal: alu_illegal};
        end else if (ready) begin
            valid_q <= 1'b0;
        end
    end

    // Retired-op counter: counts every handoff, including one coinciding with a flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (handoff) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.readyE     = ready;
    assign bus.validM     = valid_q;
    assign bus.ALUResultM = exm_q.result;
    assign bus.WriteDataM = exm_q.wdata;
    assign bus.ZeroM      = exm_q.zero;
    assign bus.IllegalM   = exm_q.illegal;
    assign bus.OpCountM   = cnt_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: scoreboard of expected EX/MEM payloads, one task per scenario.
module tb_ex_alu_stage;
    import ex_alu_stage_pkg::*;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] wd;
        logic            zero;
        logic            ill;
    } exp_t;

    typedef struct packed {
        logic [2:0]      c;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            use_imm;
        logic [XLEN-1:0] want;
    } op_vec_t;

    logic clk = 1'b0;
    logic reset;

    exp_t             sb[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [XLEN-1:0]  last_res = '0;

    always #5 clk = ~clk;

    ex_alu_stage_if bus ();

    ex_alu_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference ALU using a native signed compare for slt
    function automatic exp_t model(input logic [2:0] c, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [XLEN-1:0] wd);
        exp_t e;
        e.wd  = wd;
        e.ill = 1'b0;
        e.res = '0;
        case (c)
            3'b000:  e.res = a + b;
            3'b001:  e.res = a - b;
            3'b010:  e.res = a & b;
            3'b011:  e.res = a | b;
            3'b101:  e.res = ($signed(a) < $signed(b)) ? XLEN'(1) : XLEN'(0);
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    function automatic logic [XLEN-1:0] fwd(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                            input logic [XLEN-1:0] w, input logic [XLEN-1:0] m);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return rf;
    endfunction

    // Handoff monitor: retires the scoreboard head and tracks the expected op count
    always @(posedge clk) begin
        if (!reset && bus.validM && bus.readyM) begin
            exp_cnt = exp_cnt + CNT_W'(1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    end

    // Present one op for a single edge; caller guarantees readyE is high
    task automatic issue(input logic [2:0] c, input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
                         input logic [XLEN-1:0] imm, input logic src, input logic [1:0] fa,
                         input logic [1:0] fb, input logic [XLEN-1:0] resw, input logic flush);
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] fbv;
        exp_t            e;
        bus.validE      = 1'b1;
        bus.ALUControlE = c;
        bus.RD1E        = rd1;
        bus.RD2E        = rd2;
        bus.ImmExtE     = imm;
        bus.ALUSrcE     = src;
        bus.ForwardAE   = fa;
        bus.ForwardBE   = fb;
        bus.ResultW     = resw;
        bus.FlushM      = flush;
        a   = fwd(fa, rd1, resw, last_res);
        fbv = fwd(fb, rd2, resw, last_res);
        b   = src ? imm : fbv;
        e   = model(c, a, b, fbv);
        @(posedge clk); #1;
        bus.validE = 1'b0;
        bus.FlushM = 1'b0;
        if (!flush) begin
            sb.push_back(e);
            last_res = e.res;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.validE = 1'b0; bus.ALUControlE = 3'b000; bus.ALUSrcE = 1'b0;
        bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
        bus.RD1E = '0; bus.RD2E = '0; bus.ImmExtE = '0; bus.ResultW = '0;
        bus.FlushM = 1'b0; bus.readyM = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM, bus.OpCountM, bus.readyE}
            !== {1'b0, XLEN'(0), XLEN'(0), 1'b0, 1'b0, CNT_W'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b res=%h wd=%h z=%b ill=%b cnt=%h rdyE=%b, want all zero with readyE=1",
                     bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM, bus.OpCountM, bus.readyE);
        end
        reset = 1'b0;
        exp_cnt = '0; last_res = '0; sb.delete();
        @(posedge clk); #1;
        issue(ALU_ADD, 32'h11, 32'h0, 32'h22, 1'b1, 2'b00, 2'b00, 32'h0, 1'b0);
        @(posedge clk); #1;
        n_tests++;
        if ({bus.validM, bus.readyE, bus.ALUResultM} !== {1'b1, 1'b0, 32'h33}) begin
            n_fail++;
            $display("FAIL hold_before_reset: got v=%b rdyE=%b res=%h, want v=1 rdyE=0 res=00000033",
                     bus.validM, bus.readyE, bus.ALUResultM);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM, bus.OpCountM, bus.readyE}
            !== {1'b0, XLEN'(0), XLEN'(0), 1'b0, 1'b0, CNT_W'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset_mid_hold: got v=%b res=%h wd=%h z=%b ill=%b cnt=%h rdyE=%b, want zeros rdyE=1",
                     bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM, bus.OpCountM, bus.readyE);
        end
        sb.delete(); exp_cnt = '0; last_res = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_add();
        bus.readyM = 1'b1;
        issue(ALU_ADD, 32'd5, 32'd0, 32'd7, 1'b1, 2'b00, 2'b00, 32'd0, 1'b0);
        n_tests++;
        if ({bus.validM, bus.ALUResultM, bus.ZeroM, bus.IllegalM} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_5_7: got v=%b res=%h z=%b ill=%b, want v=1 res=0000000c z=0 ill=0",
                     bus.validM, bus.ALUResultM, bus.ZeroM, bus.IllegalM);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({bus.validM, bus.OpCountM} !== {1'b0, CNT_W'(1)}) begin
            n_fail++;
            $display("FAIL add_drain: got v=%b cnt=%h, want v=0 cnt=0001", bus.validM, bus.OpCountM);
        end
    endtask

    task automatic test_ops();
        op_vec_t tbl [7];
        tbl = '{
            '{ALU_SUB, 32'd9,        32'd9,        1'b0, 32'd0},
            '{ALU_SLT, 32'hFFFFFFFF, 32'd1,        1'b1, 32'd1},
            '{ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 1'b0, 32'd0},
            '{ALU_AND, 32'h0000F0F0, 32'h00000FF0, 1'b1, 32'h000000F0},
            '{ALU_OR,  32'h0000F000, 32'h0000000F, 1'b0, 32'h0000F00F},
            '{ALU_ADD, 32'hFFFFFFFF, 32'd1,        1'b1, 32'd0},
            '{ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 1'b0, 32'd1}
        };
        bus.readyM = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue(tbl[i].c, tbl[i].a, tbl[i].use_imm ? 32'd0 : tbl[i].b, tbl[i].use_imm ? tbl[i].b : 32'd0,
                  tbl[i].use_imm, 2'b00, 2'b00, 32'd0, 1'b0);
            n_tests++;
            if ({bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM} !== {1'b1, sb[0]}) begin
                n_fail++;
                $display("FAIL op_sb[%0d]: got {v,res,wd,z,ill}=%h want %h", i,
                         {bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM}, {1'b1, sb[0]});
            end
            n_tests++;
            if ({bus.ALUResultM, bus.ZeroM} !== {tbl[i].want, tbl[i].want == 32'd0}) begin
                n_fail++;
                $display("FAIL op_lit[%0d]: got res=%h z=%b want res=%h", i, bus.ALUResultM, bus.ZeroM, tbl[i].want);
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if ({bus.validM, bus.OpCountM} !== {1'b0, exp_cnt}) begin
            n_fail++;
            $display("FAIL ops_drain: got v=%b cnt=%h want v=0 cnt=%h", bus.validM, bus.OpCountM, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bus.readyM = 1'b1;
        for (int i = 0; i < 24; i++) begin
            issue(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom,
                  $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom, 1'b0);
            n_tests++;
            if ({bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM} !== {1'b1, sb[0]}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got {v,res,wd,z,ill}=%h want %h", i,
                         {bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM}, {1'b1, sb[0]});
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if ({bus.validM, bus.OpCountM} !== {1'b0, exp_cnt}) begin
            n_fail++;
            $display("FAIL b2b_count: got v=%b cnt=%h want v=0 cnt=%h", bus.validM, bus.OpCountM, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [CNT_W-1:0] cnt0;
        exp_t             e2;
        bus.readyM = 1'b0;
        issue(ALU_ADD, 32'd10, 32'd0, 32'd20, 1'b1, 2'b00, 2'b00, 32'd0, 1'b0);
        cnt0 = bus.OpCountM;
        bus.validE = 1'b1; bus.ALUControlE = ALU_OR; bus.RD1E = 32'd3; bus.RD2E = 32'd0;
        bus.ImmExtE = 32'd4; bus.ALUSrcE = 1'b1; bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
        e2 = model(ALU_OR, 32'd3, 32'd4, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({bus.validM, bus.readyE, bus.ALUResultM, bus.WriteDataM, bus.OpCountM}
                !== {1'b1, 1'b0, 32'd30, 32'd0, cnt0}) begin
                n_fail++;
                $display("FAIL stall[%0d]: got v=%b rdyE=%b res=%h wd=%h cnt=%h want v=1 rdyE=0 res=0000001e cnt=%h",
                         i, bus.validM, bus.readyE, bus.ALUResultM, bus.WriteDataM, bus.OpCountM, cnt0);
            end
        end
        bus.readyM = 1'b1;
        @(posedge clk); #1;
        bus.validE = 1'b0;
        sb.push_back(e2);
        last_res = e2.res;
        n_tests++;
        if ({bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM, bus.OpCountM}
            !== {1'b1, sb[0], cnt0 + CNT_W'(1)}) begin
            n_fail++;
            $display("FAIL stall_release: got {v,res,wd,z,ill}=%h cnt=%h want %h cnt=%h",
                     {bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM}, bus.OpCountM,
                     {1'b1, sb[0]}, cnt0 + CNT_W'(1));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_illegal();
        logic [CNT_W-1:0] cnt0;
        bus.readyM = 1'b1;
        cnt0 = bus.OpCountM;
        issue(ALU_ADD, 32'd1, 32'd0, 32'd1, 1'b1, 2'b00, 2'b00, 32'd0, 1'b1);
        n_tests++;
        if ({bus.validM, bus.OpCountM} !== {1'b0, cnt0}) begin
            n_fail++;
            $display("FAIL flush_accept: got v=%b cnt=%h want v=0 cnt=%h", bus.validM, bus.OpCountM, cnt0);
        end
        issue(3'b100, 32'd5, 32'd0, 32'd3, 1'b1, 2'b00, 2'b00, 32'd0, 1'b0);
        n_tests++;
        if ({bus.validM, bus.ALUResultM, bus.ZeroM, bus.IllegalM} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_100: got v=%b res=%h z=%b ill=%b want v=1 res=0 z=1 ill=1",
                     bus.validM, bus.ALUResultM, bus.ZeroM, bus.IllegalM);
        end
        cnt0 = bus.OpCountM;
        issue(ALU_ADD, 32'd2, 32'd0, 32'd2, 1'b1, 2'b00, 2'b00, 32'd0, 1'b1);
        n_tests++;
        if ({bus.validM, bus.OpCountM} !== {1'b0, cnt0 + CNT_W'(1)}) begin
            n_fail++;
            $display("FAIL flush_with_handoff: got v=%b cnt=%h want v=0 cnt=%h",
                     bus.validM, bus.OpCountM, cnt0 + CNT_W'(1));
        end
        bus.readyM = 1'b0;
        issue(ALU_SUB, 32'd8, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b0);
        cnt0 = bus.OpCountM;
        bus.FlushM = 1'b1;
        @(posedge clk); #1;
        bus.FlushM = 1'b0;
        sb.delete();
        n_tests++;
        if ({bus.validM, bus.readyE, bus.OpCountM} !== {1'b0, 1'b1, cnt0}) begin
            n_fail++;
            $display("FAIL flush_during_stall: got v=%b rdyE=%b cnt=%h want v=0 rdyE=1 cnt=%h",
                     bus.validM, bus.readyE, bus.OpCountM, cnt0);
        end
        bus.readyM = 1'b1;
    endtask

    task automatic test_forward();
        bus.readyM = 1'b1;
        issue(ALU_ADD, 32'd20, 32'd0, 32'd0, 1'b1, 2'b00, 2'b00, 32'd0, 1'b0);
        n_tests++;
        if ({bus.validM, bus.ALUResultM} !== {1'b1, 32'd20}) begin
            n_fail++;
            $display("FAIL fwd_setup: got v=%b res=%h want v=1 res=00000014", bus.validM, bus.ALUResultM);
        end
        issue(ALU_SUB, 32'd999, 32'd888, 32'd0, 1'b0, 2'b10, 2'b01, 32'd3, 1'b0);
        n_tests++;
        if ({bus.validM, bus.ALUResultM, bus.WriteDataM} !== {1'b1, 32'd17, 32'd3}) begin
            n_fail++;
            $display("FAIL fwd_sub: got v=%b res=%h wd=%h want v=1 res=00000011 wd=00000003",
                     bus.validM, bus.ALUResultM, bus.WriteDataM);
        end
        n_tests++;
        if ({bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM} !== {1'b1, sb[0]}) begin
            n_fail++;
            $display("FAIL fwd_sb: got {v,res,wd,z,ill}=%h want %h",
                     {bus.validM, bus.ALUResultM, bus.WriteDataM, bus.ZeroM, bus.IllegalM}, {1'b1, sb[0]});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int n;
        bus.readyM = 1'b1;
        n = 32'hFFFF - int'(exp_cnt);
        bus.validE = 1'b1; bus.ALUControlE = ALU_ADD; bus.ALUSrcE = 1'b1;
        bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00; bus.RD1E = 32'd1; bus.ImmExtE = 32'd1;
        repeat (n) @(posedge clk);
        #1 bus.validE = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bus.OpCountM !== CNT_W'(16'hFFFF)) begin
            n_fail++;
            $display("FAIL count_preset: got cnt=%h want ffff", bus.OpCountM);
        end
        bus.validE = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.validE = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({bus.validM, bus.OpCountM} !== {1'b0, CNT_W'(16'h0001)}) begin
            n_fail++;
            $display("FAIL count_wrap: got v=%b cnt=%h want v=0 cnt=0001", bus.validM, bus.OpCountM);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_flush_illegal();
        test_forward();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
